// File: rtl/precision_press_ctrl.sv
// Precision Button Press game controller: sweeps one lit LED across N_LEDS
// outputs and judges button presses against a switch-selected target.
module precision_press_ctrl #(
  parameter int N_LEDS         = 8,
  parameter int TICK_DIV       = 8,
  parameter int BOUNCE         = 0,
  parameter int LIVES          = 3,
  parameter int MAX_LEVEL      = 3,
  parameter int HITS_PER_LEVEL = 4,
  parameter int SCORE_W        = 8
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic                             BTN,
  input  logic [N_LEDS-1:0]                SW,
  output logic [N_LEDS-1:0]                LEDS,
  output logic                             HIT,
  output logic                             MISS,
  output logic [SCORE_W-1:0]               SCORE,
  output logic [$clog2(MAX_LEVEL+1)-1:0]   LEVEL,
  output logic [$clog2(LIVES+1)-1:0]       LIVES_LEFT,
  output logic                             GAME_OVER
);

  localparam int LW  = $clog2(MAX_LEVEL + 1);
  localparam int LVW = $clog2(LIVES + 1);
  localparam int TW  = $clog2(TICK_DIV);
  localparam int HW  = $clog2(HITS_PER_LEVEL + 1);

  localparam logic [TW-1:0]     TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [LW-1:0]     LEVEL_TOP  = LW'(MAX_LEVEL);
  localparam logic [LVW-1:0]    LIVES_INIT = LVW'(LIVES);
  localparam logic [HW-1:0]     HITS_LAST  = HW'(HITS_PER_LEVEL - 1);
  localparam logic [N_LEDS-1:0] LED_MSB    = {1'b1, {(N_LEDS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SWEEP, RESULT, OVER} state_t;

  state_t            state, state_next;
  logic              btn_meta, btn_sync, btn_prev;
  logic              press;
  logic [N_LEDS-1:0] target;
  logic [TW-1:0]     tick;
  logic [HW-1:0]     hits;
  logic              dir_up;
  logic              start;
  logic              is_hit;
  logic              step_due;
  logic              result_done;
  logic [N_LEDS-1:0] step_leds;
  logic              step_dir;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      btn_meta <= BTN;
      btn_sync <= btn_meta;
      btn_prev <= btn_sync;
    end
  end

  assign press = btn_sync & ~btn_prev;

  // (TICK_DIV >> LEVEL) - 1 equals (TICK_DIV - 1) >> LEVEL for a power-of-two TICK_DIV
  assign step_due    = (tick == (TICK_LAST >> LEVEL));
  assign result_done = (tick == TICK_LAST);
  assign is_hit      = |(LEDS & target);
  assign GAME_OVER   = (state == OVER);

  always_comb begin
    step_leds = LEDS >> 1;
    step_dir  = dir_up;
    if (BOUNCE == 0) begin
      if (LEDS[0]) step_leds = LED_MSB;
    end else if (dir_up) begin
      if (LEDS[N_LEDS-1]) step_dir = 1'b0;
      else                step_leds = LEDS << 1;
    end else if (LEDS[0]) begin
      step_leds = LEDS << 1;
      step_dir  = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    unique case (state)
      IDLE: begin
        if (press && $onehot(SW)) begin
          state_next = SWEEP;
          start      = 1'b1;
        end
      end
      SWEEP:  if (press) state_next = RESULT;
      RESULT: if (result_done) state_next = (LIVES_LEFT == '0) ? OVER : SWEEP;
      OVER:   if (press) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      LEDS       <= '0;
      HIT        <= 1'b0;
      MISS       <= 1'b0;
      SCORE      <= '0;
      LEVEL      <= '0;
      LIVES_LEFT <= LIVES_INIT;
      target     <= '0;
      tick       <= '0;
      hits       <= '0;
      dir_up     <= 1'b0;
    end else begin
      HIT  <= 1'b0;
      MISS <= 1'b0;
      unique case (state)
        IDLE: begin
          // LEDS is registered, so the target preview lags SW by one clock
          LEDS   <= SW;
          tick   <= '0;
          dir_up <= 1'b0;
          if (start) begin
            target     <= SW;
            SCORE      <= '0;
            LEVEL      <= '0;
            hits       <= '0;
            LIVES_LEFT <= LIVES_INIT;
            LEDS       <= LED_MSB;
          end
        end
        SWEEP: begin
          if (press) begin
            tick <= '0;
            if (is_hit) begin
              HIT  <= 1'b1;
              LEDS <= '1;
              if (SCORE != '1) SCORE <= SCORE + SCORE_W'(1);
              if (hits == HITS_LAST) begin
                hits <= '0;
                if (LEVEL != LEVEL_TOP) LEVEL <= LEVEL + LW'(1);
              end else begin
                hits <= hits + HW'(1);
              end
            end else begin
              MISS       <= 1'b1;
              LEDS       <= '0;
              LIVES_LEFT <= LIVES_LEFT - LVW'(1);
            end
          end else if (step_due) begin
            tick   <= '0;
            LEDS   <= step_leds;
            dir_up <= step_dir;
          end else begin
            tick <= tick + TW'(1);
          end
        end
        RESULT: begin
          if (result_done) begin
            tick   <= '0;
            dir_up <= 1'b0;
            LEDS   <= (LIVES_LEFT == '0) ? '0 : LED_MSB;
          end else begin
            tick <= tick + TW'(1);
          end
        end
        OVER: LEDS <= '0;
        default: LEDS <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_precision_press_ctrl.sv
// Bench for precision_press_ctrl: directed presses with a scoreboard of
// expected judgements, plus LED-timing and input-rule checks.
module tb_precision_press_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic       btn2 = 1'b0;
  logic [7:0] sw = 8'h00;
  logic [7:0] sw2 = 8'h01;

  logic [7:0] leds, leds2;
  logic       hit, miss, hit2, miss2;
  logic [7:0] score, score2;
  logic [1:0] level, level2, lives_left, lives_left2;
  logic       game_over, game_over2;

  precision_press_ctrl #(.N_LEDS(8), .TICK_DIV(8), .BOUNCE(0), .LIVES(3),
                         .MAX_LEVEL(3), .HITS_PER_LEVEL(4), .SCORE_W(8)) u_dut (
    .CLK(clk), .RST_N(rst_n), .BTN(btn), .SW(sw), .LEDS(leds), .HIT(hit),
    .MISS(miss), .SCORE(score), .LEVEL(level), .LIVES_LEFT(lives_left),
    .GAME_OVER(game_over));

  precision_press_ctrl #(.N_LEDS(8), .TICK_DIV(8), .BOUNCE(1), .LIVES(3),
                         .MAX_LEVEL(3), .HITS_PER_LEVEL(4), .SCORE_W(8)) u_bnc (
    .CLK(clk), .RST_N(rst_n), .BTN(btn2), .SW(sw2), .LEDS(leds2), .HIT(hit2),
    .MISS(miss2), .SCORE(score2), .LEVEL(level2), .LIVES_LEFT(lives_left2),
    .GAME_OVER(game_over2));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hit;
    logic [7:0] score;
    logic [1:0] level;
    logic [1:0] lives;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   m_score, m_level, m_hits, m_lives;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] cur(input int sel);
    return (sel != 0) ? leds2 : leds;
  endfunction

  // LED value the sweep will hold two clocks after a rising edge is applied
  // on the first cycle of the returned value
  function automatic logic [7:0] aim(input logic [7:0] led, input int lvl);
    int p;
    p = 8 >> lvl;
    return led << (2 / p);
  endfunction

  task automatic model_start();
    m_score = 0; m_level = 0; m_hits = 0; m_lives = 3;
  endtask

  task automatic model_judge(input bit h);
    exp_t e;
    if (h) begin
      if (m_score < 255) m_score++;
      m_hits++;
      if (m_hits == 4) begin
        m_hits = 0;
        if (m_level < 3) m_level++;
      end
    end else begin
      m_lives--;
    end
    e.hit = h; e.score = 8'(m_score); e.level = 2'(m_level); e.lives = 2'(m_lives);
    sb.push_back(e);
  endtask

  task automatic wait_leds(input int sel, input logic [7:0] x);
    logic [7:0] prev;
    bit found;
    prev  = cur(sel);
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (cur(sel) == x && prev != x) found = 1;
      else prev = cur(sel);
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL wait_leds: value %0h never appeared, last %0h", x, cur(sel));
    end
  endtask

  task automatic expect_run(input int sel, input logic [7:0] x, input int len, input string name);
    int n;
    check({name, "_val"}, cur(sel), x);
    n = 0;
    while (cur(sel) == x && n < 64) begin
      n++;
      @(negedge clk);
    end
    check({name, "_len"}, n, len);
  endtask

  task automatic press_judge(input logic [7:0] led, input bit h);
    logic [7:0] x;
    x = aim(led, m_level);
    wait_leds(0, x);
    model_judge(h);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && (hit || miss)) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse: hit=%0b miss=%0b, required none", hit, miss);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_hit", hit, mon_e.hit);
        check("pulse_miss", miss, !mon_e.hit);
        check("pulse_score", score, mon_e.score);
        check("pulse_level", level, mon_e.level);
        check("pulse_lives", lives_left, mon_e.lives);
        check("pulse_leds", leds, mon_e.hit ? 8'hFF : 8'h00);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] bseq [15] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                           8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  initial begin
    sw = 8'h10;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_leds", leds, 8'h00);
    check("rst_score", score, 0);
    check("rst_level", level, 0);
    check("rst_lives", lives_left, 3);
    check("rst_game_over", game_over, 0);
    check("rst_hit_miss", {hit, miss}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_preview", leds, 8'h10);

    sw = 8'h18;
    @(negedge clk);
    btn = 1'b1;
    repeat (4) @(negedge clk);
    btn = 1'b0;
    repeat (12) @(negedge clk);
    check("no_start_multi_hot", leds, 8'h18);

    sw = 8'h10;
    @(negedge clk);
    model_start();
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    expect_run(0, 8'h80, 8, "step80");
    expect_run(0, 8'h40, 8, "step40");
    expect_run(0, 8'h20, 8, "step20");
    model_judge(1);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    sw = 8'h01;
    expect_run(0, 8'hFF, 8, "result_hit");
    check("reentry_msb", leds, 8'h80);

    repeat (3) press_judge(8'h10, 1);
    check("level1", level, 1);
    wait_leds(0, 8'h40);
    expect_run(0, 8'h40, 4, "lvl1_period");
    repeat (4) press_judge(8'h10, 1);
    wait_leds(0, 8'h40);
    expect_run(0, 8'h40, 2, "lvl2_period");
    repeat (4) press_judge(8'h10, 1);
    check("level3", level, 3);
    wait_leds(0, 8'h40);
    expect_run(0, 8'h40, 1, "lvl3_period");
    press_judge(8'h10, 1);
    check("level_saturated", level, 3);

    // one long hold must give a single judgement
    wait_leds(0, aim(8'h08, m_level));
    model_judge(0);
    btn = 1'b1;
    repeat (50) @(negedge clk);
    btn = 1'b0;

    wait_leds(0, aim(8'h08, m_level));
    model_judge(0);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (2) @(negedge clk);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (2) @(negedge clk);

    press_judge(8'h08, 0);
    repeat (2) @(negedge clk);
    check("over_flag", game_over, 1);
    check("over_leds", leds, 8'h00);
    check("over_score", score, 13);
    check("over_level", level, 3);
    check("over_lives", lives_left, 0);

    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (2) @(negedge clk);
    check("over_to_idle_flag", game_over, 0);
    check("over_to_idle_leds", leds, 8'h01);
    check("idle_score_hold", score, 13);

    sw = 8'h10;
    @(negedge clk);
    model_start();
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (5) press_judge(8'h10, 1);
    check("pre_reset_score", score, 5);
    wait_leds(0, 8'h40);
    btn = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_leds", leds, 8'h00);
    check("midrst_score", score, 0);
    check("midrst_lives", lives_left, 3);
    check("midrst_level", level, 0);
    check("midrst_game_over", game_over, 0);
    btn = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_idle", leds, 8'h10);
    check("sb_empty_after_rst", sb.size(), 0);

    btn2 = 1'b1;
    repeat (3) @(negedge clk);
    btn2 = 1'b0;
    for (int i = 0; i < 15; i++) expect_run(1, bseq[i], 8, "bounce");
    check("bounce_after_msb", leds2, 8'h40);

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/precision_press_ctrl.md
Name: precision_press_ctrl

Overview:
Parametrised game controller for the Precision Button Press project. It sweeps a single lit LED across N_LEDS outputs and judges each button press against a switch-selected target LED. It tracks score, speed level and remaining lives, and drives the board LEDs and status outputs directly. Sweep length, sweep speed, wrap/bounce mode, lives and level count are all configurable.

Parameters:
N_LEDS, 8, number of LED/switch positions (≥2)
TICK_DIV, 8, clocks per sweep step at level 0; power of two, ≥ 2^MAX_LEVEL
BOUNCE, 0, 0 = wrap sweep MSB→LSB then back to MSB; 1 = ping-pong
LIVES, 3, misses allowed before game over (≥1)
MAX_LEVEL, 3, highest speed level
HITS_PER_LEVEL, 4, consecutive-or-not hits needed per level increment
SCORE_W, 8, score counter width

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
BTN  in  1  raw push button, asynchronous to CLK
SW  in  N_LEDS  target select, must be one-hot to start
LEDS  out  N_LEDS  sweep / result display
HIT  out  1  one-cycle pulse on judged hit
MISS  out  1  one-cycle pulse on judged miss
SCORE  out  SCORE_W  hit count, saturating
LEVEL  out  $clog2(MAX_LEVEL+1)  current speed level
LIVES_LEFT  out  $clog2(LIVES+1)  remaining lives
GAME_OVER  out  1  high while in OVER

Behaviour:
- Reset (RST_N low, async): state IDLE, LEDS=0, HIT=MISS=GAME_OVER=0, SCORE=0, LEVEL=0, LIVES_LEFT=LIVES, tick counter=0, direction=down.
- BTN passes through a 2-flop synchroniser. A press is the rising edge of the synchronised signal, so it is detected 2 clocks after BTN is first sampled high. Holding BTN produces one press only.
- Step period = TICK_DIV >> LEVEL clocks. The tick counter runs 0..period-1 and LEDS advance one position when it wraps.
- IDLE: LEDS=SW (target preview).
  - A press with SW exactly one-hot latches the target, clears SCORE/LEVEL/hit counter, sets LIVES_LEFT=LIVES, then → SWEEP.
  - A press with SW not one-hot is ignored.
- SWEEP:
  - Entry: LEDS=one-hot bit N_LEDS-1, tick=0, direction=down.
  - BOUNCE=0: after bit 0 the next step is bit N_LEDS-1.
  - BOUNCE=1: the sweep reverses at bit 0 and at bit N_LEDS-1, with no repeat of the end bit.
  - On a press, judge against the LEDS value in the detection cycle:
    - If (LEDS & target)≠0 → hit: SCORE+1, saturating at all-ones. The hit counter increments; when it reaches HITS_PER_LEVEL it clears and LEVEL+1, saturating at MAX_LEVEL.
    - Otherwise → miss: LIVES_LEFT-1.
  - HIT/MISS are registered and pulse high for exactly 1 clock, the cycle after detection. Then → RESULT.
  - Latched target changes only in IDLE; SW changes during play are ignored.
- RESULT: lasts TICK_DIV clocks. LEDS=all ones after a hit, all zeros after a miss. Presses are ignored. Exit → OVER if LIVES_LEFT=0, else → SWEEP (re-entry rules apply, new LEVEL period).
- OVER: GAME_OVER=1, LEDS=0. SCORE/LEVEL hold. A press → IDLE (GAME_OVER clears next cycle).
- A level change takes effect at the next SWEEP entry only; the period never changes mid-sweep.
- Mid-game reset: all state returns to reset values immediately; a press already in the synchroniser is discarded.

Test Plan:
- Hit: N_LEDS=8, TICK_DIV=8, SW=8'b00010000, press in IDLE; LEDS steps 0x80→0x40→0x20→0x10 every 8 clocks. Raise BTN so detection falls while LEDS=0x10 → HIT pulse 1 clock, SCORE=1, LEDS=0xFF for 8 clocks, then LEDS=0x80.
- Miss/game over: same setup, press detected at LEDS=0x08 three times → three MISS pulses, LIVES_LEFT 3→2→1→0. After the last RESULT, GAME_OVER=1 and LEDS=0. A press → IDLE with LEDS=SW.
- Level/speed: 4 hits → LEVEL=1; next SWEEP steps every 4 clocks. 12 hits total → LEVEL=3 (1-clock steps); further hits leave LEVEL=3.
- Bounce: BOUNCE=1, no press; LEDS sequence 0x80…0x01, 0x02…0x80, 0x40, with 0x01 and 0x80 each appearing once per turn.
- Input rules: SW=8'b00011000 plus press in IDLE → stays IDLE. Holding BTN high for 50 clocks in SWEEP → exactly one judgement. A press during RESULT → no HIT/MISS.
- Reset mid-SWEEP with SCORE=5: RST_N low → LEDS=0, SCORE=0, LIVES_LEFT=3, IDLE, with no HIT/MISS after release.
